// File: rtl/moving_average_pkg.sv
// Shared types and address helpers for the multi-channel ADC boxcar averager.
package moving_average_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WRITE
  } state_t;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int idx_width(input int addr_w, input int channels);
    return addr_w - 1 - ch_width(channels);
  endfunction

  // Capture-memory address layout, MSB first: {bank, channel, index}.
  function automatic logic [31:0] pack_addr(input logic bank, input logic [31:0] ch,
                                            input logic [31:0] idx, input int ch_w,
                                            input int idx_w);
    return (32'(bank) << (ch_w + idx_w)) | (ch << idx_w) | idx;
  endfunction

endpackage

// File: rtl/moving_average_multi_if.sv
// Switch-side write port of the ping-pong capture memory.
interface moving_average_multi_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic              WCLK_SW;
  logic              WENA_SW;
  logic [ADDR_W-1:0] WADDR_SW;
  logic [DATA_W-1:0] DATA_SW;
  logic [1:0]        BUFREADY;

  modport master (output WCLK_SW, WENA_SW, WADDR_SW, DATA_SW, BUFREADY);
  modport slave  (input  WCLK_SW, WENA_SW, WADDR_SW, DATA_SW, BUFREADY);
endinterface

// File: rtl/ma_channel.sv
// One channel of the boxcar averager: sample history, running sum, floor average.
module ma_channel #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg
);
  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_W + WIN_LOG2;

  logic [DATA_W-1:0] hist [DEPTH];
  logic [SUM_W-1:0]  sum;

  // NOTE: the history is reset on purpose; the post-reset ramp is defined
  // behaviour and depends on every slot starting at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (load) begin
      sum     <= sum - SUM_W'(hist[DEPTH-1]) + SUM_W'(sample);
      hist[0] <= sample;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign avg = sum[SUM_W-1:WIN_LOG2];

endmodule

// File: rtl/moving_average_multi.sv
// ADC clock divider, capture/write sequencer and ping-pong address/flag logic.
module moving_average_multi
  import moving_average_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 3,
  parameter int ADDR_W   = 12,
  parameter int DIV_HALF = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       ENA,
  input  logic                       MODE,
  input  logic [CHANNELS*DATA_W-1:0] INPUT_ADC,
  output logic [CHANNELS-1:0]        CLK_ADC,
  moving_average_multi_if.master     sw
);
  localparam int CH_W  = ch_width(CHANNELS);
  localparam int IDX_W = idx_width(ADDR_W, CHANNELS);
  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  // The whole write burst must fit in one sample period.
  if (DIV_HALF < 1 || 2 * DIV_HALF < CHANNELS + 2 || IDX_W < 1) begin : g_param_check
    $error("moving_average_multi: DIV_HALF too small for CHANNELS, or ADDR_W too narrow");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              clk_adc;
  logic              div_end, strobe;
  state_t            state, state_nx;
  logic              capture, write;
  logic [CH_W-1:0]   ch_cnt;
  logic [IDX_W-1:0]  idx;
  logic              bank;
  logic [1:0]        bufready;
  logic              mode_q;
  logic              last_ch, first_write, last_write;
  logic [DATA_W-1:0] sample_w [CHANNELS];
  logic [DATA_W-1:0] raw_q    [CHANNELS];
  logic [DATA_W-1:0] avg_w    [CHANNELS];

  assign div_end = (div_cnt == DIV_W'(DIV_HALF - 1));
  assign strobe  = div_end & clk_adc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      clk_adc <= 1'b0;
    end else if (div_end) begin
      div_cnt <= '0;
      clk_adc <= ~clk_adc;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign CLK_ADC = {CHANNELS{clk_adc}};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  assign last_ch = (ch_cnt == CH_W'(CHANNELS - 1));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    write    = 1'b0;
    case (state)
      IDLE:    if (strobe && ENA) state_nx = CAPTURE;
      CAPTURE: begin
        capture  = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        write = 1'b1;
        if (last_ch) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign first_write = (ch_cnt == '0) && (idx == '0);
  assign last_write  = last_ch && (idx == '1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q   <= 1'b0;
      ch_cnt   <= '0;
      idx      <= '0;
      bank     <= 1'b0;
      bufready <= 2'b00;
    end else begin
      if (capture) begin
        mode_q <= MODE;
        ch_cnt <= '0;
      end
      if (write) begin
        if (first_write) bufready[bank] <= 1'b0;
        if (last_write)  bufready[bank] <= 1'b1;
        if (last_ch) begin
          ch_cnt <= '0;
          idx    <= idx + IDX_W'(1);
          if (idx == '1) bank <= ~bank;
        end else begin
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign sample_w[k] = INPUT_ADC[k*DATA_W +: DATA_W];

    ma_channel #(
      .DATA_W  (DATA_W),
      .WIN_LOG2(WIN_LOG2)
    ) u_ch (
      .CLK   (CLK),
      .RST_N (RST_N),
      .load  (capture),
      .sample(sample_w[k]),
      .avg   (avg_w[k])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < CHANNELS; k++) raw_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < CHANNELS; k++) raw_q[k] <= sample_w[k];
    end
  end

  assign sw.WCLK_SW  = CLK;
  assign sw.WENA_SW  = write;
  assign sw.WADDR_SW = ADDR_W'(pack_addr(bank, 32'(ch_cnt), 32'(idx), CH_W, IDX_W));
  assign sw.DATA_SW  = !write ? '0 : (mode_q ? raw_q[ch_cnt] : avg_w[ch_cnt]);
  assign sw.BUFREADY = bufready;

endmodule

// File: tb/tb_moving_average_multi.sv
// Directed bench: ramp, raw latency, ENA pause, async reset, ping-pong flags, 4-channel saturation.
module tb_moving_average_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_b_n = 1'b0;
  logic        ena_a = 1'b1, mode_a = 1'b0;
  logic        ena_b = 1'b1, mode_b = 1'b0;
  logic [15:0] adc_a = {8'd40, 8'd100};
  logic [31:0] adc_b = {4{8'd255}};
  logic [1:0]  clk_adc_a;
  logic [3:0]  clk_adc_b;

  int n_cmp = 0;
  int n_bad = 0;
  int a_idx = 0;
  int h0 [8];
  int h1 [8];

  moving_average_multi_if #(.DATA_W(8), .ADDR_W(12)) if_a ();
  moving_average_multi_if #(.DATA_W(8), .ADDR_W(12)) if_b ();

  moving_average_multi #(
    .CHANNELS(2), .DATA_W(8), .WIN_LOG2(3), .ADDR_W(12), .DIV_HALF(4)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .ENA(ena_a), .MODE(mode_a),
    .INPUT_ADC(adc_a), .CLK_ADC(clk_adc_a), .sw(if_a.master)
  );

  moving_average_multi #(
    .CHANNELS(4), .DATA_W(8), .WIN_LOG2(4), .ADDR_W(12), .DIV_HALF(3)
  ) dut_b (
    .CLK(clk), .RST_N(rst_b_n), .ENA(ena_b), .MODE(mode_b),
    .INPUT_ADC(adc_b), .CLK_ADC(clk_adc_b), .sw(if_b.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ramp(input int v, input int n, input int win);
    return 32'((v * ((n < win) ? n : win)) / win);
  endfunction

  task automatic wait_wena_a(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (if_a.WENA_SW) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wena_b(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (if_b.WENA_SW) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_adc_a(input logic lvl, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (clk_adc_a[0] == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One averaged set on DUT A, bank 0; ends on the idle cycle after the burst.
  task automatic set_a(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    logic ok;
    wait_wena_a(ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check({tag, "_addr0"}, 32'(if_a.WADDR_SW), 32'(a_idx));
    check({tag, "_d0"}, 32'(if_a.DATA_SW), e0);
    @(negedge clk);
    check({tag, "_wena1"}, 32'(if_a.WENA_SW), 32'd1);
    check({tag, "_addr1"}, 32'(if_a.WADDR_SW), 32'h400 | 32'(a_idx));
    check({tag, "_d1"}, 32'(if_a.DATA_SW), e1);
    @(negedge clk);
    check({tag, "_end"}, 32'(if_a.WENA_SW), 32'd0);
    a_idx++;
  endtask

  // ADC data changes after the CLK_ADC rise; writes must land at capture+1+k.
  task automatic latency_set(input logic [7:0] d0, input logic [7:0] d1, input logic m,
                             input logic [31:0] e0, input logic [31:0] e1);
    logic ok;
    wait_adc_a(1'b1, ok);
    check("adc_rise", 32'(ok), 32'd1);
    adc_a  = {d1, d0};
    mode_a = m;
    wait_adc_a(1'b0, ok);
    check("adc_fall", 32'(ok), 32'd1);
    check("lat_capture_idle", 32'(if_a.WENA_SW), 32'd0);
    @(negedge clk);
    check("lat_ch0_wena", 32'(if_a.WENA_SW), 32'd1);
    check("lat_ch0_addr", 32'(if_a.WADDR_SW), 32'(a_idx));
    check("lat_ch0_data", 32'(if_a.DATA_SW), e0);
    @(negedge clk);
    check("lat_ch1_wena", 32'(if_a.WENA_SW), 32'd1);
    check("lat_ch1_data", 32'(if_a.DATA_SW), e1);
    @(negedge clk);
    check("lat_end", 32'(if_a.WENA_SW), 32'd0);
    a_idx++;
  endtask

  task automatic run_sets_a(input int n);
    logic ok;
    int   got = 0;
    for (int i = 0; i < n; i++) begin
      wait_wena_a(ok);
      if (ok) got++;
      repeat (2) @(negedge clk);
    end
    check("run_sets_done", 32'(got), 32'(n));
  endtask

  initial begin
    logic        ok;
    logic [7:0]  d0, d1;
    int          s0, s1, hi;

    // NOTE: bench stimulus is driven with blocking assignments away from the active edge.
    repeat (2) @(negedge clk);
    check("rst_wena", 32'(if_a.WENA_SW), 32'd0);
    check("rst_waddr", 32'(if_a.WADDR_SW), 32'd0);
    check("rst_data", 32'(if_a.DATA_SW), 32'd0);
    check("rst_bufready", 32'(if_a.BUFREADY), 32'd0);
    check("rst_clk_adc", 32'(clk_adc_a), 32'd0);
    check("wclk_follows_clk", 32'(if_a.WCLK_SW), 32'(clk));
    rst_n = 1'b1;

    // Constant 100 / 40 in averaging mode: ramp, then steady.
    for (int n = 1; n <= 10; n++) set_a("ramp", ramp(100, n, 8), ramp(40, n, 8));

    // Raw mode with random samples, then back to averaging.
    for (int i = 0; i < 8; i++) begin h0[i] = 100; h1[i] = 40; end
    for (int s = 0; s < 10; s++) begin
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      for (int i = 7; i > 0; i--) begin h0[i] = h0[i-1]; h1[i] = h1[i-1]; end
      h0[0] = int'(d0);
      h1[0] = int'(d1);
      if (s < 9) begin
        latency_set(d0, d1, 1'b1, 32'(d0), 32'(d1));
      end else begin
        s0 = 0; s1 = 0;
        for (int i = 0; i < 8; i++) begin s0 += h0[i]; s1 += h1[i]; end
        latency_set(d0, d1, 1'b0, 32'(s0 / 8), 32'(s1 / 8));
      end
    end

    // Asynchronous reset in the middle of the ch0 write.
    wait_wena_a(ok);
    check("pre_rst_in_write", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wena", 32'(if_a.WENA_SW), 32'd0);
    check("async_rst_waddr", 32'(if_a.WADDR_SW), 32'd0);
    check("async_rst_data", 32'(if_a.DATA_SW), 32'd0);
    check("async_rst_bufready", 32'(if_a.BUFREADY), 32'd0);
    check("async_rst_clk_adc", 32'(clk_adc_a), 32'd0);
    adc_a  = {8'd40, 8'd100};
    mode_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    a_idx = 0;
    for (int n = 1; n <= 3; n++) set_a("post_rst", ramp(100, n, 8), ramp(40, n, 8));

    // ENA dropped during a ch0 write: burst completes, then nothing, then resume.
    wait_wena_a(ok);
    check("ena_seen", 32'(ok), 32'd1);
    check("ena_ch0_addr", 32'(if_a.WADDR_SW), 32'd3);
    check("ena_ch0_data", 32'(if_a.DATA_SW), 32'd50);
    ena_a = 1'b0;
    @(negedge clk);
    check("ena_ch1_wena", 32'(if_a.WENA_SW), 32'd1);
    check("ena_ch1_addr", 32'(if_a.WADDR_SW), 32'h403);
    check("ena_ch1_data", 32'(if_a.DATA_SW), 32'd20);
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (if_a.WENA_SW) hi++;
    end
    check("ena_off_writes", 32'(hi), 32'd0);
    check("ena_off_addr_hold", 32'(if_a.WADDR_SW), 32'd4);
    ena_a = 1'b1;
    a_idx = 4;
    set_a("resume", 32'd62, 32'd25);

    // Ping-pong bank flags across two full banks of 1024 sets.
    run_sets_a(1018);
    check("bank0_not_full", 32'(if_a.BUFREADY), 32'b00);
    check("bank0_last_addr", 32'(if_a.WADDR_SW), 32'd1023);
    run_sets_a(1);
    check("bank0_full", 32'(if_a.BUFREADY), 32'b01);
    check("bank1_first_addr", 32'(if_a.WADDR_SW), 32'h800);
    run_sets_a(1024);
    check("both_full", 32'(if_a.BUFREADY), 32'b11);
    check("wrap_addr", 32'(if_a.WADDR_SW), 32'h000);
    wait_wena_a(ok);
    check("reuse_seen", 32'(ok), 32'd1);
    check("reuse_addr", 32'(if_a.WADDR_SW), 32'h000);
    check("reuse_flags_during", 32'(if_a.BUFREADY), 32'b11);
    @(negedge clk);
    check("reuse_flags_after", 32'(if_a.BUFREADY), 32'b10);

    // Four channels, 16-point window, full-scale input.
    check("b_rst_wena", 32'(if_b.WENA_SW), 32'd0);
    check("b_rst_waddr", 32'(if_b.WADDR_SW), 32'd0);
    check("b_rst_clk_adc", 32'(clk_adc_b), 32'd0);
    rst_b_n = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      wait_wena_b(ok);
      check("b_seen", 32'(ok), 32'd1);
      for (int k = 0; k < 4; k++) begin
        check("b_wena", 32'(if_b.WENA_SW), 32'd1);
        check("b_addr", 32'(if_b.WADDR_SW), 32'((k << 9) | (n - 1)));
        check("b_data", 32'(if_b.DATA_SW), ramp(255, n, 16));
        @(negedge clk);
      end
      check("b_burst_len", 32'(if_b.WENA_SW), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/moving_average_multi.md
# moving_average_multi

Parametrised multi-channel ADC front end and boxcar averager. It generates the ADC sample clocks and captures CHANNELS parallel ADC words on each sample period. It computes a 2^WIN_LOG2-point running average per channel, or passes raw samples through, and streams the results into the ping-pong capture memory on the switch side with per-bank ready flags. It succeeds the fixed two-channel, 8-bit averager in the capture path.

## Interface
- CHANNELS, 2, number of ADC channels (≥1)
- DATA_W, 8, ADC sample width
- WIN_LOG2, 3, log2 of averaging window length (0 = no averaging)
- ADDR_W, 12, capture memory address width
- DIV_HALF, 4, CLK cycles per ADC clock half-period; elaboration error unless 2*DIV_HALF ≥ CHANNELS+2
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- ENA  in  1  capture enable
- MODE  in  1  0 = averaged output, 1 = raw sample output
- INPUT_ADC  in  CHANNELS*DATA_W  ADC data, channel k in bits [k*DATA_W +: DATA_W]
- CLK_ADC  out  CHANNELS  ADC sample clocks, all in phase
- WCLK_SW  out  1  memory write clock, equal to CLK
- WENA_SW  out  1  memory write enable, one-cycle pulses
- WADDR_SW  out  ADDR_W  write address {bank, channel, index}
- DATA_SW  out  DATA_W  write data
- BUFREADY  out  2  per-bank full flags

## Operation
- Derived widths: CH_W = max(1, clog2(CHANNELS)); IDX_W = ADDR_W-1-CH_W. Bank size = 2^IDX_W sample sets.
- Divider: CLK_ADC toggles every DIV_HALF CLK cycles and runs regardless of ENA.
- The ADC updates data on the CLK_ADC rising edge. Data is captured on the CLK cycle where CLK_ADC goes 1→0.
- FSM: IDLE → CAPTURE → WRITE(ch 0..CHANNELS-1) → IDLE.
  - IDLE → CAPTURE on the capture strobe when ENA=1.
  - CAPTURE: latch all channels and update every history/sum.
  - WRITE: one channel per cycle.
- Per channel, a history shift register of depth 2^WIN_LOG2 holds samples. Running sum is DATA_W+WIN_LOG2 bits: sum ← sum − oldest + new. This cannot overflow.
- Average = sum >> WIN_LOG2 (floor, truncate).
- After reset the history is zero, so the first 2^WIN_LOG2−1 outputs are a ramp. This is defined behaviour with no warm-up flag.
- MODE is sampled at CAPTURE. History and sums update in both modes, so switching to MODE=0 yields a valid average immediately.
- Address: bank bit, then channel, then index. The index increments after the last channel write. When the index wraps, the bank toggles.
- BUFREADY[b] sets on the final write of bank b and clears on the first write into bank b.
- ENA=0:
  - No new CAPTURE starts.
  - An in-progress WRITE sequence completes.
  - Address, history and flags hold.
- RST_N low (async): all state clears immediately. This includes mid-sequence, and the aborted sequence is lost.

## Timing
- Reset values:
  - CLK_ADC=0, WENA_SW=0, WADDR_SW=0, DATA_SW=0, BUFREADY=00.
  - FSM=IDLE, bank=0, index=0, sums/history=0.
- Capture at cycle t. Channel k write appears at t+1+k: WENA_SW=1 with valid WADDR_SW/DATA_SW.
- WENA_SW is never high for more than CHANNELS consecutive cycles.
- Sample period is 2*DIV_HALF cycles. The write burst always ends before the next strobe.
- BUFREADY updates on the edge after the qualifying write, registered alongside it.
- Simultaneous set/clear of BUFREADY on the same bit is impossible: a bank is never both finished and restarted in one write.

## Structure
- Package moving_average_pkg holds:
  - the FSM state enum (IDLE, CAPTURE, WRITE);
  - functions deriving CH_W/IDX_W;
  - the address field packing function.
- Sub-module ma_channel (one instance per channel) contains:
  - history shift register, running sum and average output;
  - parameters DATA_W, WIN_LOG2; ports CLK, RST_N, load, sample, avg.
- Top level holds the divider, FSM, address counters and BUFREADY.

## Test plan
- Defaults, ch0 constant 100, ch1 constant 40, MODE=0: ch0 writes 12,25,37,50,62,75,87,100 then 100 forever. ch1 writes 5,10,…,40 then 40. Addresses are 0x000, 0x400, 0x001, 0x401, ….
- MODE=1 with random ADC data: DATA_SW equals the sample latched at the CLK_ADC fall. Channel k write lands exactly at capture+1+k. Switching to MODE=0 after ≥8 sets gives the correct average on the next set.
- Run 2048 sample sets:
  - after set 1024, BUFREADY=01 and the next address is 0x800;
  - after set 2048, BUFREADY=11;
  - the next write (0x000) makes BUFREADY=10.
- Drop ENA for 50 cycles mid-stream: the current burst finishes, then there are no writes. Index and sums hold, and capture resumes at the next address on re-enable.
- Assert RST_N during the ch0 write: outputs go to reset values without waiting for CLK. After release, the first write is to address 0 with the ramp restarting from 0.
- All-255 input with CHANNELS=4, WIN_LOG2=4, DIV_HALF=3: average reaches 255 and never wraps. Channel field is 2 bits and bank size is 512.
